// File: rtl/inst_mem_loader_if.sv
// Byte-stream handshake and instruction-memory write bus of the boot loader.
interface inst_mem_loader_if;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        MemWrite;
  logic [15:0] MemAddress;
  logic [7:0]  MemData;

  // Host side: drives the byte stream, observes memory writes.
  modport master (
    output ByteIn,
    output ByteValid,
    input  ByteReady,
    input  MemWrite,
    input  MemAddress,
    input  MemData
  );

  // Loader side: consumes the byte stream, drives memory writes.
  modport slave (
    input  ByteIn,
    input  ByteValid,
    output ByteReady,
    output MemWrite,
    output MemAddress,
    output MemData
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot-time instruction memory loader: parses a framed byte stream
// (LEN_HI, LEN_LO, 4*N payload bytes, CSUM) and writes each payload byte
// to ascending byte addresses starting at BASE_ADDR.
module inst_mem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned MAX_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  inst_mem_loader_if.slave bus,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [15:0] WordCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] word_count;
  logic [17:0] byte_cnt;
  logic [7:0]  sum;
  logic        mem_write;
  logic [15:0] mem_address;
  logic [7:0]  mem_data;

  logic        ready;
  logic        xfer;
  logic [15:0] len_word;
  logic [17:0] last_idx;

  // Handshake decode: readiness depends on state only, never on ByteValid.
  always_comb begin
    ready    = (state == S_LEN_HI) || (state == S_LEN_LO) ||
               (state == S_DATA)   || (state == S_CSUM);
    xfer     = ready && bus.ByteValid;
    len_word = {len_hi, bus.ByteIn};
    last_idx = {word_count, 2'b00} - 18'd1;
  end

  // Frame parser, byte counter, running checksum and registered write port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      len_hi      <= '0;
      word_count  <= '0;
      byte_cnt    <= '0;
      sum         <= '0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
    end else begin
      mem_write <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (Start) begin
            state    <= S_LEN_HI;
            byte_cnt <= '0;
            sum      <= '0;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_hi <= bus.ByteIn;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            word_count <= len_word;
            if ({16'h0000, len_word} > MAX_WORDS)
              state <= S_ERROR;
            else if (len_word == 16'h0000)
              state <= S_CSUM;
            else
              state <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            mem_write   <= 1'b1;
            mem_address <= BASE_ADDR + byte_cnt[15:0];
            mem_data    <= bus.ByteIn;
            sum         <= sum + bus.ByteIn;
            byte_cnt    <= byte_cnt + 18'd1;
            if (byte_cnt == last_idx)
              state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (xfer)
            state <= (bus.ByteIn == sum) ? S_DONE : S_ERROR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status and bus outputs; Done/Error are sticky because the terminal
  // states persist until the next Start.
  always_comb begin
    bus.ByteReady  = ready;
    bus.MemWrite   = mem_write;
    bus.MemAddress = mem_address;
    bus.MemData    = mem_data;
    Busy           = ready;
    Done           = (state == S_DONE);
    Error          = (state == S_ERROR);
    WordCount      = word_count;
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader: two instances share the
// stimulus, one at base 0x0000 and one at base 0xFFFE for wrap-around.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_in = 8'h00;

  logic        busy0, done0, err0, busy1, done1, err1;
  logic [15:0] wc0, wc1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [23:0] q0[$];
  logic [23:0] q1[$];
  logic [7:0]  frame[$];
  logic [7:0]  pay[$];

  always #5 clk = ~clk;

  inst_mem_loader_if bus0();
  inst_mem_loader_if bus1();

  assign bus0.ByteIn    = byte_in;
  assign bus0.ByteValid = byte_valid;
  assign bus1.ByteIn    = byte_in;
  assign bus1.ByteValid = byte_valid;

  inst_mem_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(16384)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .Start     (start),
    .bus       (bus0),
    .Busy      (busy0),
    .Done      (done0),
    .Error     (err0),
    .WordCount (wc0)
  );

  inst_mem_loader #(.BASE_ADDR(16'hFFFE), .MAX_WORDS(16384)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .Start     (start),
    .bus       (bus1),
    .Busy      (busy1),
    .Done      (done1),
    .Error     (err1),
    .WordCount (wc1)
  );

  // Capture every memory write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus0.MemWrite === 1'b1) q0.push_back({bus0.MemAddress, bus0.MemData});
    if (bus1.MemWrite === 1'b1) q1.push_back({bus1.MemAddress, bus1.MemData});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {ByteReady, Busy, Done, Error, WordCount} of instance 0.
  task automatic chk_status0(input string tag, input logic bsy, input logic dn,
                             input logic er, input logic [15:0] wc);
    chk(tag, 64'({bus0.ByteReady, busy0, done0, err0, wc0}),
        64'({bsy, bsy, dn, er, wc}));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dut0"}, 64'({bus0.ByteReady, bus0.MemWrite, bus0.MemAddress, bus0.MemData,
                             busy0, done0, err0, wc0}), 64'd0);
    chk({tag, "_dut1"}, 64'({bus1.ByteReady, bus1.MemWrite, bus1.MemAddress, bus1.MemData,
                             busy1, done1, err1, wc1}), 64'd0);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    byte_valid = 1'b0;
    repeat (gap) begin
      byte_in = 8'($urandom);
      @(posedge clk);
      #1;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input int maxgap);
    foreach (frame[i]) send(frame[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int sel, input logic [15:0] base);
    logic [23:0] q[$];
    logic [15:0] a;
    if (sel == 0) q = q0;
    else          q = q1;
    chk({tag, "_count"}, 64'(q.size()), 64'(pay.size()));
    foreach (pay[i]) begin
      a = base + 16'(i);
      if (i < q.size())
        chk($sformatf("%s_w%0d", tag, i), 64'(q[i]), 64'({a, pay[i]}));
    end
  endtask

  task automatic load_good_frame;
    frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04, 8'hC6};
    pay   = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
  endtask

  initial begin
    // Reset held with random inputs: everything reads zero, no writes.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      start      = 1'($urandom);
      byte_valid = 1'($urandom);
      byte_in    = 8'($urandom);
      @(negedge clk);
      chk_all_zero($sformatf("reset_hold%0d", i));
    end
    chk("reset_no_writes", 64'(q0.size() + q1.size()), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0;
    @(negedge clk);
    chk_status0("idle_after_reset", 1'b0, 1'b0, 1'b0, 16'h0000);

    // Good load, continuous valid.
    load_good_frame();
    q0.delete(); q1.delete();
    pulse_start();
    chk_status0("busy_after_start", 1'b1, 1'b0, 1'b0, 16'h0000);
    send_frame(0);
    @(negedge clk);
    chk_status0("good_status", 1'b0, 1'b1, 1'b0, 16'd2);
    check_writes("good", 0, 16'h0000);

    // Good load with random gaps.
    q0.delete(); q1.delete();
    pulse_start();
    chk_status0("start_clears_done", 1'b1, 1'b0, 1'b0, 16'd2);
    send_frame(3);
    @(negedge clk);
    chk_status0("gap_status", 1'b0, 1'b1, 1'b0, 16'd2);
    check_writes("gap", 0, 16'h0000);

    // Bad checksum.
    q0.delete(); q1.delete();
    frame[10] = 8'hC7;
    pulse_start();
    send_frame(0);
    @(negedge clk);
    chk_status0("badsum_status", 1'b0, 1'b0, 1'b1, 16'd2);
    check_writes("badsum", 0, 16'h0000);

    // Recovery after error.
    load_good_frame();
    q0.delete(); q1.delete();
    pulse_start();
    chk_status0("start_clears_error", 1'b1, 1'b0, 1'b0, 16'd2);
    send_frame(0);
    @(negedge clk);
    chk_status0("recover_status", 1'b0, 1'b1, 1'b0, 16'd2);

    // Length over MAX_WORDS: error straight after LEN_LO, no writes.
    q0.delete(); q1.delete();
    frame = '{8'h40, 8'h01};
    pulse_start();
    send_frame(0);
    @(negedge clk);
    chk_status0("toolong_status", 1'b0, 1'b0, 1'b1, 16'h4001);
    chk("toolong_no_writes", 64'(q0.size()), 64'd0);

    // Zero length with checksum 00.
    frame = '{8'h00, 8'h00, 8'h00};
    pulse_start();
    send_frame(0);
    @(negedge clk);
    chk_status0("zero_len_good", 1'b0, 1'b1, 1'b0, 16'h0000);
    chk("zero_len_no_writes", 64'(q0.size()), 64'd0);

    // Zero length with nonzero checksum.
    frame = '{8'h00, 8'h00, 8'h01};
    pulse_start();
    send_frame(0);
    @(negedge clk);
    chk_status0("zero_len_bad", 1'b0, 1'b0, 1'b1, 16'h0000);

    // Address wrap on the 0xFFFE instance, Start pulsed during DATA.
    q0.delete(); q1.delete();
    pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    pulse_start();
    send(8'h00, 0);
    send(8'h01, 0);
    start = 1'b1;
    send(8'hAA, 0);
    send(8'hBB, 1);
    start = 1'b0;
    send(8'hCC, 0);
    send(8'hDD, 0);
    send(8'h0E, 0);
    @(negedge clk);
    chk("wrap_status", 64'({bus1.ByteReady, busy1, done1, err1, wc1}),
        64'({1'b0, 1'b0, 1'b1, 1'b0, 16'd1}));
    check_writes("wrap", 1, 16'hFFFE);

    // Reset after three payload bytes, then a full good load.
    load_good_frame();
    q0.delete(); q1.delete();
    pulse_start();
    for (int i = 0; i < 5; i++) send(frame[i], 0);
    rst = 1'b0;
    #1;
    chk_all_zero("midreset_async");
    for (int i = 0; i < 3; i++) begin
      byte_valid = 1'b1;
      byte_in    = 8'($urandom);
      @(negedge clk);
      chk_all_zero($sformatf("midreset_hold%0d", i));
    end
    chk("midreset_writes", 64'(q0.size()), 64'd2);
    @(posedge clk);
    #1;
    rst = 1'b1; byte_valid = 1'b0;
    q0.delete(); q1.delete();
    pulse_start();
    send_frame(0);
    @(negedge clk);
    chk_status0("after_reset_status", 1'b0, 1'b1, 1'b0, 16'd2);
    check_writes("after_reset", 0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
